// File: rtl/credit_tx.sv
// credit_tx: transmit-side credit flow-control stage.
// Accepts an upstream valid/ready stream and forwards it as a registered,
// credit-gated valid-only stream. The remote receiver returns one credit per
// consumed beat. Supports a flush/drain handshake and a sticky overflow flag.
//
// state | meaning
// ------+----------------------------------------------------------------
// LOAD  | one-cycle (re)initialisation of the credit count from INIT_CREDIT
// RUN   | normal streaming; beats sent while credits are available
// DRAIN | no new beats; wait until all outstanding credits have come back
module credit_tx #(
  parameter int DATA_WIDTH   = 16,
  parameter int CREDIT_WIDTH = 4,
  parameter int MAX_CREDIT   = 8
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [CREDIT_WIDTH-1:0] INIT_CREDIT,
  input  logic                    FLUSH,
  input  logic                    IN_VAL,
  input  logic [DATA_WIDTH-1:0]   IN_DAT,
  output logic                    IN_RDY,
  output logic                    OUT_VAL,
  output logic [DATA_WIDTH-1:0]   OUT_DAT,
  input  logic                    CREDIT_RET,
  output logic [CREDIT_WIDTH-1:0] CREDIT_CNT,
  output logic                    FLUSH_DONE,
  output logic                    ERR_OVF
);

  localparam logic [CREDIT_WIDTH-1:0] MAX_C = CREDIT_WIDTH'(MAX_CREDIT);
  localparam logic [CREDIT_WIDTH-1:0] ONE_C = {{(CREDIT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                  state;
  logic [CREDIT_WIDTH-1:0] credit;
  logic [CREDIT_WIDTH-1:0] init_reg;
  logic                    out_val;
  logic [DATA_WIDTH-1:0]   out_dat;
  logic                    flush_done;
  logic                    err_ovf;

  logic                    in_rdy;
  logic                    send;
  logic [CREDIT_WIDTH-1:0] init_clamp;
  logic [CREDIT_WIDTH-1:0] credit_next;
  logic                    ovf_hit;

  // Ready comes from registered state only, so a same-cycle return never
  // bypasses the zero-credit stall.
  assign in_rdy     = (state == RUN) && (credit != '0);
  assign send       = IN_VAL & in_rdy;
  assign init_clamp = (INIT_CREDIT > MAX_C) ? MAX_C : INIT_CREDIT;

  // Saturating up/down credit update; a return at full count is an overflow.
  always_comb begin
    credit_next = credit;
    ovf_hit     = 1'b0;
    if (CREDIT_RET && !send) begin
      if (credit == MAX_C) begin
        ovf_hit = 1'b1;
      end else begin
        credit_next = credit + ONE_C;
      end
    end else if (send && !CREDIT_RET) begin
      credit_next = credit - ONE_C;
    end
  end

  // Control FSM, credit counter, output register and status flags.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= LOAD;
      credit     <= '0;
      init_reg   <= '0;
      out_val    <= 1'b0;
      out_dat    <= '0;
      flush_done <= 1'b0;
      err_ovf    <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      out_val    <= send;
      if (send) begin
        out_dat <= IN_DAT;
      end
      case (state)
        LOAD: begin
          credit   <= init_clamp;
          init_reg <= init_clamp;
          // Any return here has no outstanding beat to match; drop and flag.
          if (CREDIT_RET) begin
            err_ovf <= 1'b1;
          end
          state <= RUN;
        end
        RUN: begin
          credit <= credit_next;
          if (ovf_hit) begin
            err_ovf <= 1'b1;
          end
          if (FLUSH) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          credit <= credit_next;
          if (ovf_hit) begin
            err_ovf <= 1'b1;
          end
          // Registered count back at its loaded value: nothing in flight.
          if (credit >= init_reg) begin
            flush_done <= 1'b1;
            state      <= LOAD;
          end
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

  assign IN_RDY     = in_rdy;
  assign OUT_VAL    = out_val;
  assign OUT_DAT    = out_dat;
  assign CREDIT_CNT = credit;
  assign FLUSH_DONE = flush_done;
  assign ERR_OVF    = err_ovf;

endmodule

// File: tb/tb_credit_tx.sv
// Testbench for credit_tx: directed stimulus, scoreboard queue of expected
// payloads checked by an independent output monitor.
module tb_credit_tx;

  logic        clk;
  logic        reset_n;
  logic [3:0]  init_credit;
  logic        flush;
  logic        in_val;
  logic [15:0] in_dat;
  logic        in_rdy;
  logic        out_val;
  logic [15:0] out_dat;
  logic        credit_ret;
  logic [3:0]  credit_cnt;
  logic        flush_done;
  logic        err_ovf;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];

  credit_tx #(.DATA_WIDTH(16), .CREDIT_WIDTH(4), .MAX_CREDIT(8)) dut (
    .CLK        (clk),
    .RESET_N    (reset_n),
    .INIT_CREDIT(init_credit),
    .FLUSH      (flush),
    .IN_VAL     (in_val),
    .IN_DAT     (in_dat),
    .IN_RDY     (in_rdy),
    .OUT_VAL    (out_val),
    .OUT_DAT    (out_dat),
    .CREDIT_RET (credit_ret),
    .CREDIT_CNT (credit_cnt),
    .FLUSH_DONE (flush_done),
    .ERR_OVF    (err_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: every beat must match the oldest expected payload.
  always @(negedge clk) begin
    if (reset_n && out_val) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got data %0h expected no beat at %0t", out_dat, $time);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (out_dat !== e) begin
          errors++;
          $display("FAIL out_dat: got %0h expected %0h at %0t", out_dat, e, $time);
        end
      end
    end
  end

  initial begin
    reset_n     = 1'b0;
    init_credit = 4'd8;
    flush       = 1'b0;
    in_val      = 1'b0;
    in_dat      = 16'h0;
    credit_ret  = 1'b0;
    repeat (3) tick();
    chk("rst_in_rdy", in_rdy, 0);
    chk("rst_out_val", out_val, 0);
    chk("rst_out_dat", out_dat, 0);
    chk("rst_credit", credit_cnt, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_err", err_ovf, 0);

    // Full-credit burst: 8 beats, then stall.
    reset_n = 1'b1;
    tick();
    chk("load_credit8", credit_cnt, 8);
    chk("run_rdy", in_rdy, 1);
    in_val = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_dat = 16'hA000 + 16'(i);
      exp_q.push_back(in_dat);
      chk("burst_credit", credit_cnt, 32'(8 - i));
      tick();
    end
    in_dat = 16'hA0FF;
    tick();
    chk("empty_rdy", in_rdy, 0);
    chk("empty_credit", credit_cnt, 0);

    // Return with zero credit does not bypass the stall.
    in_dat     = 16'hB001;
    credit_ret = 1'b1;
    chk("zero_ret_rdy", in_rdy, 0);
    tick();
    credit_ret = 1'b0;
    chk("ret1_rdy", in_rdy, 1);
    chk("ret1_credit", credit_cnt, 1);
    exp_q.push_back(in_dat);
    tick();
    in_val = 1'b0;
    chk("ret1_sent_credit", credit_cnt, 0);
    chk("ret1_sent_rdy", in_rdy, 0);

    // Credit 3 with simultaneous send and return.
    credit_ret = 1'b1;
    repeat (3) tick();
    chk("credit3", credit_cnt, 3);
    in_val = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_dat = 16'hC000 + 16'(i);
      exp_q.push_back(in_dat);
      tick();
      chk("sendret_credit", credit_cnt, 3);
    end
    in_val     = 1'b0;
    credit_ret = 1'b0;
    tick();
    chk("sendret_err", err_ovf, 0);

    // Saturation at MAX_CREDIT.
    credit_ret = 1'b1;
    repeat (5) tick();
    chk("credit_max", credit_cnt, 8);
    chk("no_err_yet", err_ovf, 0);
    tick();
    credit_ret = 1'b0;
    chk("sat_credit", credit_cnt, 8);
    chk("sat_err", err_ovf, 1);
    in_val = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_dat = 16'hD000 + 16'(i);
      exp_q.push_back(in_dat);
      tick();
    end
    chk("after_traffic_credit", credit_cnt, 6);
    chk("err_sticky", err_ovf, 1);

    // Mid-stream asynchronous reset.
    in_dat = 16'hE000;
    tick();
    chk("pre_rst_out_val", out_val, 1);
    reset_n = 1'b0;
    #1;
    in_val = 1'b0;
    chk("mid_rst_out_val", out_val, 0);
    chk("mid_rst_rdy", in_rdy, 0);
    chk("mid_rst_credit", credit_cnt, 0);
    chk("mid_rst_err", err_ovf, 0);

    // INIT_CREDIT above MAX is clamped.
    init_credit = 4'd15;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    chk("clamp_credit", credit_cnt, 8);
    chk("clamp_rdy", in_rdy, 1);

    // Flush/drain with INIT_CREDIT=4.
    reset_n     = 1'b0;
    init_credit = 4'd4;
    tick();
    reset_n = 1'b1;
    tick();
    chk("load4_credit", credit_cnt, 4);
    in_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_dat = 16'hF000 + 16'(i);
      exp_q.push_back(in_dat);
      tick();
    end
    in_val = 1'b0;
    chk("drained_credit", credit_cnt, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("drain_rdy", in_rdy, 0);
    chk("drain_fd", flush_done, 0);
    for (int k = 0; k < 4; k++) begin
      credit_ret = 1'b1;
      tick();
      credit_ret = 1'b0;
      chk("drain_ret_credit", credit_cnt, 32'(k + 1));
      chk("drain_ret_rdy", in_rdy, 0);
      chk("drain_ret_fd", flush_done, 0);
      if (k < 3) begin
        tick();
        chk("drain_gap_fd", flush_done, 0);
        tick();
        chk("drain_gap_rdy", in_rdy, 0);
      end
    end
    init_credit = 4'd2;
    tick();
    chk("flush_done_pulse", flush_done, 1);
    chk("load_rdy", in_rdy, 0);
    credit_ret = 1'b1;
    tick();
    credit_ret = 1'b0;
    chk("reload_credit", credit_cnt, 2);
    chk("fd_one_cycle", flush_done, 0);
    chk("load_ret_err", err_ovf, 1);
    chk("reload_rdy", in_rdy, 1);

    // INIT_CREDIT=0: drain completes immediately.
    reset_n     = 1'b0;
    init_credit = 4'd0;
    tick();
    reset_n = 1'b1;
    tick();
    chk("zero_init_credit", credit_cnt, 0);
    chk("zero_init_rdy", in_rdy, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("zero_drain_fd", flush_done, 1);
    tick();
    chk("zero_drain_fd_clear", flush_done, 0);

    repeat (2) tick();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
